// File: rtl/uart_pkg.sv
// Shared UART definitions for the receive and transmit stages.
//   rx_state_t               : receiver FSM state encoding
//   CLOCKS_PER_PULSE_DEFAULT : default system clocks per serial bit
//   DATA_BITS / STOP_LEVEL   : 8N1 frame constants
package uart_pkg;

    localparam int   CLOCKS_PER_PULSE_DEFAULT = 16;
    localparam int   DATA_BITS                = 8;
    localparam logic STOP_LEVEL               = 1'b1;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for signals asynchronous to clk.
//   clk : destination clock
//   rst : asynchronous active-high reset; both flops load RESET_VALUE
//   d   : asynchronous input
//   q   : synchronized output, two clk cycles behind d
module sync_2ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments here so both flops sample their inputs
    // from before the edge; blocking would collapse the chain into one stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART 8N1 receive stage: serial rx line to parallel bytes.
//   clk         : system clock, rising edge
//   rst         : asynchronous active-high reset
//   rx          : serial input, idle high, asynchronous to clk
//   data_out    : last correctly framed byte, held until the next good frame
//   data_valid  : one-cycle pulse when data_out is updated
//   frame_error : one-cycle pulse when the stop bit is sampled low
//   rx_busy     : high whenever the FSM is outside RX_IDLE
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_PULSE = CLOCKS_PER_PULSE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       rx_busy
);

    localparam int             CW        = $clog2(CLOCKS_PER_PULSE);
    localparam logic [CW-1:0]  HALF_LAST = CW'(CLOCKS_PER_PULSE / 2 - 1);
    localparam logic [CW-1:0]  BIT_LAST  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [2:0]     IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 rx_sync;
    rx_state_t            state, state_next;
    logic [CW-1:0]        clk_count, clk_count_next;
    logic [2:0]           bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_reg_next;
    logic [7:0]           data_out_next;
    logic                 data_valid_next, frame_error_next;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start.
    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_sync)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RX_IDLE;
            clk_count   <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            data_out    <= 8'h00;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            rx_busy     <= 1'b0;
        end else begin
            state       <= state_next;
            clk_count   <= clk_count_next;
            bit_idx     <= bit_idx_next;
            shift_reg   <= shift_reg_next;
            data_out    <= data_out_next;
            data_valid  <= data_valid_next;
            frame_error <= frame_error_next;
            // Registered from the next state so it tracks state exactly.
            rx_busy     <= (state_next != RX_IDLE);
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_next       = state;
        clk_count_next   = clk_count;
        bit_idx_next     = bit_idx;
        shift_reg_next   = shift_reg;
        data_out_next    = data_out;
        data_valid_next  = 1'b0;
        frame_error_next = 1'b0;

        case (state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    state_next     = RX_START;
                    clk_count_next = '0;
                end
            end

            // Re-check the line at mid start bit to reject short glitches.
            RX_START: begin
                if (clk_count == HALF_LAST) begin
                    if (!rx_sync) begin
                        state_next     = RX_DATA;
                        clk_count_next = '0;
                        bit_idx_next   = '0;
                    end else begin
                        state_next     = RX_IDLE;
                    end
                end else begin
                    clk_count_next = clk_count + CW'(1);
                end
            end

            // Sampling is aligned to mid-bit because the count started there.
            RX_DATA: begin
                if (clk_count == BIT_LAST) begin
                    shift_reg_next = {rx_sync, shift_reg[DATA_BITS-1:1]};
                    clk_count_next = '0;
                    if (bit_idx == IDX_LAST) begin
                        state_next   = RX_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    clk_count_next = clk_count + CW'(1);
                end
            end

            // Leaving at mid stop bit leaves half a bit of margin for a
            // back-to-back start edge or a slightly fast transmitter.
            RX_STOP: begin
                if (clk_count == BIT_LAST) begin
                    clk_count_next = '0;
                    if (rx_sync == STOP_LEVEL) begin
                        data_out_next   = shift_reg;
                        data_valid_next = 1'b1;
                        state_next      = RX_IDLE;
                    end else begin
                        frame_error_next = 1'b1;
                        state_next       = RX_BREAK;
                    end
                end else begin
                    clk_count_next = clk_count + CW'(1);
                end
            end

            // A line held low after a bad stop bit must not look like a start.
            RX_BREAK: begin
                if (rx_sync) begin
                    state_next = RX_IDLE;
                end
            end

            default: begin
                state_next = RX_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed testbench for uart_receiver at 16 clocks per bit.
module tb_uart_receiver;

    localparam int CPP = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx  = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_error;
    logic       rx_busy;

    int cyc       = 0;
    int n_cmp     = 0;
    int n_err     = 0;
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int both_cnt  = 0;

    logic [7:0] data_q[$];
    int         vcyc_q[$];
    logic [7:0] exp_q[$];

    uart_receiver #(
        .CLOCKS_PER_PULSE (CPP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (data_valid) begin
            valid_cnt <= valid_cnt + 1;
            data_q.push_back(data_out);
            vcyc_q.push_back(cyc);
        end
        if (frame_error) ferr_cnt <= ferr_cnt + 1;
        if (data_valid && frame_error) both_cnt <= both_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; drives rx and waits n falling edges.
    task automatic hold(input logic b, input int n);
        rx = b;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, output int c0);
        c0 = cyc;
        hold(1'b0, CPP);
        for (int i = 0; i < 8; i++) hold(b[i], CPP);
        hold(stop, CPP);
    endtask

    initial begin
        int c0;
        int base_v;
        int base_f;
        logic [7:0] b;

        // ---------------- reset ----------------
        #1 rst = 1'b1;
        #2;
        check("reset data_out", 32'(data_out), 32'h00);
        check("reset data_valid", 32'(data_valid), 32'd0);
        check("reset frame_error", 32'(frame_error), 32'd0);
        check("reset rx_busy", 32'(rx_busy), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hold(1'b1, 5);

        // ---------------- single frame 0xA5 ----------------
        send_frame(8'hA5, 1'b1, c0);
        hold(1'b1, 4);
        check("single valid count", 32'(valid_cnt), 32'd1);
        check("single strobe cycle", 32'(vcyc_q.size() > 0 ? vcyc_q[0] : -1), 32'(c0 + 155));
        check("single data_out", 32'(data_out), 32'hA5);
        check("single no frame_error", 32'(ferr_cnt), 32'd0);

        // ---------------- back-to-back 0x00, 0xFF ----------------
        data_q.delete();
        vcyc_q.delete();
        send_frame(8'h00, 1'b1, c0);
        send_frame(8'hFF, 1'b1, c0);
        hold(1'b1, 4);
        check("b2b pulse count", 32'(data_q.size()), 32'd2);
        if (data_q.size() == 2) begin
            check("b2b first byte", 32'(data_q[0]), 32'h00);
            check("b2b second byte", 32'(data_q[1]), 32'hFF);
            check("b2b spacing", 32'(vcyc_q[1] - vcyc_q[0]), 32'd160);
        end
        check("b2b no frame_error", 32'(ferr_cnt), 32'd0);

        // ---------------- false start ----------------
        base_v = valid_cnt;
        base_f = ferr_cnt;
        hold(1'b0, 4);
        check("false start busy rises", 32'(rx_busy), 32'd1);
        hold(1'b0, 1);
        hold(1'b1, 8);
        check("false start busy falls", 32'(rx_busy), 32'd0);
        hold(1'b1, 10);
        check("false start no valid", 32'(valid_cnt), 32'(base_v));
        check("false start no frame_error", 32'(ferr_cnt), 32'(base_f));

        // ---------------- framing error ----------------
        send_frame(8'h3C, 1'b1, c0);
        hold(1'b1, 4);
        check("ferr pre byte", 32'(data_out), 32'h3C);
        base_v = valid_cnt;
        send_frame(8'h55, 1'b0, c0);
        hold(1'b0, 40);
        check("ferr pulse count", 32'(ferr_cnt), 32'(base_f + 1));
        check("ferr no valid", 32'(valid_cnt), 32'(base_v));
        check("ferr data_out held", 32'(data_out), 32'h3C);
        check("ferr busy in break", 32'(rx_busy), 32'd1);
        hold(1'b1, 1);
        check("ferr busy until rx_sync high", 32'(rx_busy), 32'd1);
        hold(1'b1, 4);
        check("ferr busy released", 32'(rx_busy), 32'd0);
        send_frame(8'h81, 1'b1, c0);
        hold(1'b1, 4);
        check("ferr recovery byte", 32'(data_out), 32'h81);
        check("ferr recovery valid", 32'(valid_cnt), 32'(base_v + 1));
        check("ferr single pulse", 32'(ferr_cnt), 32'(base_f + 1));

        // ---------------- reset mid-frame (0xF0, bit 4) ----------------
        base_v = valid_cnt;
        base_f = ferr_cnt;
        b = 8'hF0;
        hold(1'b0, CPP);
        for (int i = 0; i < 4; i++) hold(b[i], CPP);
        hold(b[4], CPP / 2);
        #2 rst = 1'b1;
        #1;
        check("midreset data_out", 32'(data_out), 32'h00);
        check("midreset data_valid", 32'(data_valid), 32'd0);
        check("midreset frame_error", 32'(frame_error), 32'd0);
        check("midreset rx_busy", 32'(rx_busy), 32'd0);
        rx = 1'b1;
        @(negedge clk);
        hold(1'b1, 3);
        rst = 1'b0;
        hold(1'b1, 4);
        check("midreset no valid", 32'(valid_cnt), 32'(base_v));
        check("midreset no frame_error", 32'(ferr_cnt), 32'(base_f));
        send_frame(8'h12, 1'b1, c0);
        hold(1'b1, 4);
        check("midreset recovery byte", 32'(data_out), 32'h12);
        check("midreset recovery valid", 32'(valid_cnt), 32'(base_v + 1));

        // ---------------- loopback stream of random bytes ----------------
        base_f = ferr_cnt;
        data_q.delete();
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(b);
            send_frame(b, 1'b1, c0);
        end
        hold(1'b1, 20);
        check("loopback count", 32'(data_q.size()), 32'd256);
        if (data_q.size() == 256) begin
            for (int i = 0; i < 256; i++) begin
                check($sformatf("loopback byte %0d", i), 32'(data_q[i]), 32'(exp_q[i]));
            end
        end
        check("loopback no frame_error", 32'(ferr_cnt), 32'(base_f));
        check("strobes never coincide", 32'(both_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
